axi_lite_regfile_n: RTL and testbench
=====================================

Name: axi_lite_regfile_n

Overview:
- Parametrised AXI4-Lite slave register file; successor to the fixed 4-register Register_File slave.
- Generalises the register count, adds byte write strobes, SLVERR on out-of-range addresses, and a hardware-side write port.
- Adds per-register write-commit pulses so fabric logic can react to software writes.
- Sits between the AXI interconnect (BFM master in simulation) and processing-array control/status logic.

Parameters:
- NUM_REGS, 16, number of 32-bit registers (1..64).
- C_S_AXI_ADDR_WIDTH, 8, byte address width; must satisfy 2^(C_S_AXI_ADDR_WIDTH-2) >= NUM_REGS.
- RESET_VALUE, 32'h00000000, reset value of every register.

Ports:
- S_AXI_ACLK  in  1  clock; all logic on rising edge.
- S_AXI_ARESET  in  1  asynchronous, active-high reset.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write byte address.
- S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  write address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in/out  1  write data handshake.
- S_AXI_BRESP  out  2  00 OKAY, 10 SLVERR.
- S_AXI_BVALID / S_AXI_BREADY  out/in  1  write response handshake.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read byte address.
- S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  read address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  00 OKAY, 10 SLVERR.
- S_AXI_RVALID / S_AXI_RREADY  out/in  1  read data handshake.
- hw_we  in  NUM_REGS  per-register hardware write enable.
- hw_wdata  in  NUM_REGS*32  flat hardware write data; register i uses bits [32i+31:32i].
- regs_out  out  NUM_REGS*32  flat current register contents.
- wr_pulse  out  NUM_REGS  one-cycle pulse on an AXI write commit to register i.

Behaviour:
- Reset (asynchronous, any time, including mid-transaction):
  - All registers = RESET_VALUE.
  - AWREADY = WREADY = ARREADY = 1.
  - BVALID = RVALID = 0; BRESP = RRESP = 00; RDATA = 0; wr_pulse = 0.
  - Both FSMs return to IDLE; any pending transaction is discarded.
- Register index = address[C_S_AXI_ADDR_WIDTH-1:2]; address bits [1:0] are ignored.
- Write FSM states:
  - IDLE: AWREADY = WREADY = 1.
  - HAVE_ADDR: AWREADY = 0, WREADY = 1.
  - HAVE_DATA: AWREADY = 1, WREADY = 0.
  - RESP: both readies = 0.
  - Each channel's handshake latches its payload. AW and W are accepted in either order or in the same cycle.
  - On the edge where the second of AW/W completes: commit the write, set BVALID = 1, enter RESP.
  - BVALID and BRESP hold until BREADY = 1; then BVALID clears and the FSM returns to IDLE on the next edge.
  - No new AW or W is accepted while in RESP.
- Commit rules:
  - Index < NUM_REGS: bytes with WSTRB[b] = 1 are updated, other bytes are unchanged; wr_pulse[index] = 1 for exactly the next cycle; BRESP = 00.
  - WSTRB = 0000: no byte changes, but wr_pulse still fires and BRESP = 00.
  - Index >= NUM_REGS: no register changes, no wr_pulse, BRESP = 10.
- Read FSM states:
  - IDLE: ARREADY = 1.
  - On the AR handshake edge: RDATA = register[index] (the value before any commit on that same edge); RRESP = 00; RVALID = 1; ARREADY = 0.
  - Index >= NUM_REGS: RDATA = 0, RRESP = 10.
  - RDATA, RRESP and RVALID hold stable until RREADY = 1; then RVALID clears and ARREADY = 1 on the next edge.
  - Read latency: RVALID asserts 1 cycle after the AR handshake.
- Read and write FSMs are independent and may operate concurrently.
- Hardware write: hw_we[i] = 1 loads hw_wdata slice i on the edge.
- Same-edge collision on one register: AXI commit wins on strobed bytes; hw_wdata supplies the unstrobed bytes.
- regs_out is driven directly from the register flops (zero latency after an update).

Test Plan:
- Reset, then read all NUM_REGS registers -> every RDATA = RESET_VALUE, RRESP = 00.
- For i = 0..3, write 0101FFFF, abcd0001, dead0011, beef0011 with WSTRB = F, then read back -> data matches, BRESP = RRESP = 00, wr_pulse[i] high for 1 cycle per write.
- W presented 3 cycles before AW, then AW at 0x08 with data 12345678 -> single commit on the AW edge; BVALID held while BREADY = 0 for 5 cycles; reg2 = 12345678.
- Write reg1 = FFFFFFFF, then write 00000000 with WSTRB = 0101 -> reg1 reads back FF00FF00.
- Write and read at index NUM_REGS -> BRESP = 10, RRESP = 10, RDATA = 0, no register changes, no wr_pulse.
- Same-edge hw_we[3] with hw_wdata = AAAAAAAA and AXI write 55555555, WSTRB = 0011, to reg3 -> reg3 = AAAA5555.
- Assert reset while BVALID = 1 -> BVALID = 0, AWREADY = 1, registers = RESET_VALUE.

Source files
------------

// File: rtl/axi_lite_regfile_n.sv
// axi_lite_regfile_n: AXI4-Lite slave holding NUM_REGS 32-bit registers with byte strobes,
// SLVERR on out-of-range indices, a hardware write port and per-register write-commit pulses.
module axi_lite_regfile_n #(
    parameter int          NUM_REGS           = 16,
    parameter int          C_S_AXI_ADDR_WIDTH = 8,
    parameter logic [31:0] RESET_VALUE        = 32'h00000000
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [31:0]                   S_AXI_WDATA,
    input  logic [3:0]                    S_AXI_WSTRB,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [31:0]                   S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    input  logic [NUM_REGS-1:0]           hw_we,
    input  logic [NUM_REGS*32-1:0]        hw_wdata,
    output logic [NUM_REGS*32-1:0]        regs_out,
    output logic [NUM_REGS-1:0]           wr_pulse
);
    localparam int IW = C_S_AXI_ADDR_WIDTH - 2;
    localparam logic [IW:0] NR = (IW+1)'(NUM_REGS);

    typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_VALID} r_state_t;

    w_state_t ws;
    r_state_t rs;
    logic [IW-1:0] aw_idx_q, c_idx, ar_idx;
    logic [31:0] wdata_q, c_data, rd_mux;
    logic [3:0] wstrb_q, c_strb;
    logic aw_hs, w_hs, commit;
    logic [NUM_REGS*32-1:0] regs_nx;
    logic [NUM_REGS-1:0] pulse_nx;
    logic unused_addr_lsbs;

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs = S_AXI_WVALID && S_AXI_WREADY;
    // Commit on the edge where the second of AW/W lands, whichever order they came in
    assign commit = (aw_hs || ws == W_HAVE_ADDR) && (w_hs || ws == W_HAVE_DATA);
    assign c_idx = aw_hs ? S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2] : aw_idx_q;
    assign c_data = w_hs ? S_AXI_WDATA : wdata_q;
    assign c_strb = w_hs ? S_AXI_WSTRB : wstrb_q;
    assign ar_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign unused_addr_lsbs = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Hardware load first, so strobed AXI bytes override it on a same-edge collision
    always_comb begin
        regs_nx = regs_out;
        pulse_nx = '0;
        rd_mux = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (hw_we[i]) regs_nx[32*i +: 32] = hw_wdata[32*i +: 32];
            if (commit && c_idx == IW'(i)) begin
                pulse_nx[i] = 1'b1;
                for (int b = 0; b < 4; b++)
                    if (c_strb[b]) regs_nx[32*i+8*b +: 8] = c_data[8*b +: 8];
            end
            if (ar_idx == IW'(i)) rd_mux = regs_out[32*i +: 32];
        end
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            ws <= W_IDLE;
            S_AXI_AWREADY <= 1'b1;
            S_AXI_WREADY <= 1'b1;
            S_AXI_BVALID <= 1'b0;
            S_AXI_BRESP <= 2'b00;
            aw_idx_q <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            regs_out <= {NUM_REGS{RESET_VALUE}};
            wr_pulse <= '0;
        end else begin
            regs_out <= regs_nx;
            wr_pulse <= pulse_nx;
            if (aw_hs) aw_idx_q <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
            if (w_hs) begin
                wdata_q <= S_AXI_WDATA;
                wstrb_q <= S_AXI_WSTRB;
            end
            if (commit) begin
                ws <= W_RESP;
                S_AXI_AWREADY <= 1'b0;
                S_AXI_WREADY <= 1'b0;
                S_AXI_BVALID <= 1'b1;
                S_AXI_BRESP <= ({1'b0, c_idx} < NR) ? 2'b00 : 2'b10;
            end else if (aw_hs) begin
                ws <= W_HAVE_ADDR;
                S_AXI_AWREADY <= 1'b0;
            end else if (w_hs) begin
                ws <= W_HAVE_DATA;
                S_AXI_WREADY <= 1'b0;
            end else if (ws == W_RESP && S_AXI_BREADY) begin
                ws <= W_IDLE;
                S_AXI_AWREADY <= 1'b1;
                S_AXI_WREADY <= 1'b1;
                S_AXI_BVALID <= 1'b0;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            rs <= R_IDLE;
            S_AXI_ARREADY <= 1'b1;
            S_AXI_RVALID <= 1'b0;
            S_AXI_RRESP <= 2'b00;
            S_AXI_RDATA <= '0;
        end else if (rs == R_IDLE) begin
            if (S_AXI_ARVALID) begin
                rs <= R_VALID;
                S_AXI_ARREADY <= 1'b0;
                S_AXI_RVALID <= 1'b1;
                S_AXI_RDATA <= rd_mux;
                S_AXI_RRESP <= ({1'b0, ar_idx} < NR) ? 2'b00 : 2'b10;
            end
        end else if (S_AXI_RREADY) begin
            rs <= R_IDLE;
            S_AXI_ARREADY <= 1'b1;
            S_AXI_RVALID <= 1'b0;
        end
    end
endmodule

// File: tb/tb_axi_lite_regfile_n.sv
// tb_axi_lite_regfile_n: randomized AXI-Lite and hardware-port traffic against an
// array-of-registers reference model, plus the directed corner cases.
module tb_axi_lite_regfile_n;
    localparam int N = 16;
    localparam logic [31:0] RV = 32'h5A5A0000;

    logic tb_ACLK = 1'b0;
    logic tb_ARESET = 1'b1;
    logic [7:0] S_AXI_AWADDR = '0, S_AXI_ARADDR = '0;
    logic S_AXI_AWVALID = 0, S_AXI_WVALID = 0, S_AXI_BREADY = 0, S_AXI_ARVALID = 0, S_AXI_RREADY = 0;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0] S_AXI_WSTRB = '0;
    logic S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID;
    logic [1:0] S_AXI_BRESP, S_AXI_RRESP;
    logic [31:0] S_AXI_RDATA;
    logic [N-1:0] hw_we = '0, wr_pulse;
    logic [N*32-1:0] hw_wdata = '0, regs_out;

    logic [31:0] model [N];
    int n_chk = 0, n_pass = 0;

    axi_lite_regfile_n #(.NUM_REGS(N), .C_S_AXI_ADDR_WIDTH(8), .RESET_VALUE(RV)) dut (
        .S_AXI_ACLK(tb_ACLK), .S_AXI_ARESET(tb_ARESET),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
        .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .hw_we(hw_we), .hw_wdata(hw_wdata), .regs_out(regs_out), .wr_pulse(wr_pulse)
    );

    always #5 tb_ACLK = ~tb_ACLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge tb_ACLK);
        #1;
    endtask

    task automatic check_all();
        for (int i = 0; i < N; i++) check($sformatf("regs_out[%0d]", i), regs_out[32*i +: 32], model[i]);
    endtask

    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int adly, input int wdly, input int hold,
                             output logic [1:0] resp, output logic [N-1:0] p0, output logic [N-1:0] p1);
        bit ad = 0, wd = 0, a, w;
        S_AXI_BREADY = 0;
        p1 = '0;
        for (int c = 0; c < 40 && !(ad && wd); c++) begin
            if (!ad && c >= adly) begin S_AXI_AWVALID = 1; S_AXI_AWADDR = addr; end
            if (!wd && c >= wdly) begin S_AXI_WVALID = 1; S_AXI_WDATA = data; S_AXI_WSTRB = strb; end
            a = S_AXI_AWVALID && S_AXI_AWREADY;
            w = S_AXI_WVALID && S_AXI_WREADY;
            tick();
            hw_we = '0;
            if (a) begin S_AXI_AWVALID = 0; ad = 1; end
            if (w) begin S_AXI_WVALID = 0; wd = 1; end
            if (ad != wd) check("no_early_bvalid", S_AXI_BVALID, 0);
        end
        check("wr_handshake", {ad, wd}, 2'b11);
        check("bvalid", S_AXI_BVALID, 1);
        resp = S_AXI_BRESP;
        p0 = wr_pulse;
        for (int k = 0; k <= hold; k++) begin
            if (k == hold) S_AXI_BREADY = 1;
            tick();
            if (k == 0) p1 = wr_pulse;
            if (k < hold) check("bvalid_hold", S_AXI_BVALID, 1);
        end
        S_AXI_BREADY = 0;
        check("bvalid_clear", S_AXI_BVALID, 0);
        check("aw_w_ready_idle", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b11);
    endtask

    task automatic do_write(input int idx, input logic [31:0] data, input logic [3:0] strb,
                            input int adly, input int wdly, input int hold);
        logic [1:0] resp;
        logic [N-1:0] p0, p1, ep;
        ep = '0;
        if (idx < N) begin
            ep[idx] = 1'b1;
            for (int b = 0; b < 4; b++) if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
        end
        axi_write(8'(idx * 4 + $urandom_range(0, 3)), data, strb, adly, wdly, hold, resp, p0, p1);
        check("bresp", resp, idx < N ? 2'b00 : 2'b10);
        check("wr_pulse_commit", p0, ep);
        check("wr_pulse_after", p1, '0);
    endtask

    task automatic do_read(input int idx, input int hold);
        bit got = 0, a;
        logic [31:0] exp = idx < N ? model[idx] : 32'h0;
        S_AXI_ARADDR = 8'(idx * 4 + $urandom_range(0, 3));
        S_AXI_ARVALID = 1;
        S_AXI_RREADY = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            a = S_AXI_ARVALID && S_AXI_ARREADY;
            tick();
            if (a) begin got = 1; S_AXI_ARVALID = 0; end
        end
        check("ar_handshake", got, 1);
        check("rvalid", S_AXI_RVALID, 1);
        check("arready_low", S_AXI_ARREADY, 0);
        check("rdata", S_AXI_RDATA, exp);
        check("rresp", S_AXI_RRESP, idx < N ? 2'b00 : 2'b10);
        for (int k = 0; k < hold; k++) begin
            tick();
            check("rvalid_hold", S_AXI_RVALID, 1);
            check("rdata_hold", S_AXI_RDATA, exp);
        end
        S_AXI_RREADY = 1;
        tick();
        S_AXI_RREADY = 0;
        check("rvalid_clear", S_AXI_RVALID, 0);
        check("arready_back", S_AXI_ARREADY, 1);
    endtask

    task automatic do_hw(input int idx, input logic [31:0] data);
        hw_wdata[32*idx +: 32] = data;
        hw_we[idx] = 1'b1;
        tick();
        hw_we = '0;
        model[idx] = data;
        check("hw_write", regs_out[32*idx +: 32], data);
    endtask

    initial begin
        logic [31:0] d [4] = '{32'h0101FFFF, 32'habcd0001, 32'hdead0011, 32'hbeef0011};
        for (int i = 0; i < N; i++) model[i] = RV;
        tick();
        tick();
        tb_ARESET = 0;
        tick();
        check("rst_readies", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
        check("rst_valids", {S_AXI_BVALID, S_AXI_RVALID}, 2'b00);
        check("rst_resp", {S_AXI_BRESP, S_AXI_RRESP}, 4'b0000);
        check("rst_rdata", S_AXI_RDATA, 0);
        check("rst_wr_pulse", wr_pulse, 0);
        check_all();
        for (int i = 0; i < N; i++) do_read(i, 0);

        for (int i = 0; i < 4; i++) do_write(i, d[i], 4'hF, 0, 0, 0);
        for (int i = 0; i < 4; i++) do_read(i, 1);
        check("reg2_plan", regs_out[95:64], 32'hdead0011);

        do_write(2, 32'h12345678, 4'hF, 3, 0, 5);
        check("reg2_w_before_aw", regs_out[95:64], 32'h12345678);

        do_write(1, 32'hFFFFFFFF, 4'hF, 0, 2, 0);
        do_write(1, 32'h00000000, 4'b0101, 1, 0, 0);
        check("reg1_strobe", regs_out[63:32], 32'hFF00FF00);
        do_read(1, 0);

        do_write(5, 32'hCAFEF00D, 4'h0, 0, 0, 1);
        check("reg5_zero_strobe", regs_out[191:160], RV);

        do_write(N, 32'hDEADBEEF, 4'hF, 0, 1, 0);
        check_all();
        do_read(N, 2);

        hw_wdata[32*3 +: 32] = 32'hAAAAAAAA;
        hw_we[3] = 1'b1;
        model[3] = 32'hAAAAAAAA;
        do_write(3, 32'h55555555, 4'b0011, 0, 0, 0);
        check("reg3_collision", regs_out[127:96], 32'hAAAA5555);
        do_read(3, 0);

        for (int it = 0; it < 200; it++) begin
            case ($urandom_range(0, 2))
                0: do_write($urandom_range(0, N + 3), $urandom, 4'($urandom_range(0, 15)),
                            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
                1: do_read($urandom_range(0, N + 3), $urandom_range(0, 2));
                default: do_hw($urandom_range(0, N - 1), $urandom);
            endcase
            check_all();
        end

        S_AXI_AWADDR = 8'h14;
        S_AXI_WDATA = 32'h0BADC0DE;
        S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1;
        S_AXI_WVALID = 1;
        S_AXI_BREADY = 0;
        tick();
        S_AXI_AWVALID = 0;
        S_AXI_WVALID = 0;
        check("pre_rst_bvalid", S_AXI_BVALID, 1);
        tb_ARESET = 1;
        #2;
        check("mid_rst_bvalid", S_AXI_BVALID, 0);
        check("mid_rst_awready", S_AXI_AWREADY, 1);
        for (int i = 0; i < N; i++) model[i] = RV;
        check_all();
        tick();
        tb_ARESET = 0;
        tick();
        check("post_rst_bvalid", S_AXI_BVALID, 0);
        do_read(5, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
